// File: rtl/cnl_sweep_pkg.sv
// Shared types and constants for the sweep job sequencer: FSM states, config
// select codes, table limits and the job_parameters field layout.
package cnl_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_CMPL,
    ST_ACK,
    ST_ADVANCE,
    ST_DONE
  } sweep_state_e;

  localparam logic [2:0] CFG_IMG      = 3'd0;
  localparam logic [2:0] CFG_STRD     = 3'd1;
  localparam logic [2:0] CFG_PAD      = 3'd2;
  localparam logic [2:0] CFG_KRNL     = 3'd3;
  localparam logic [2:0] CFG_UPS_MASK = 3'd4;

  // Tables are always built at their maximum depth; index widths match exactly.
  localparam int MAX_IMG    = 8;
  localparam int MAX_STRD   = 4;
  localparam int MAX_PAD    = 4;
  localparam int MAX_KRNL   = 16;
  localparam int IMG_IDX_W  = 3;
  localparam int STRD_IDX_W = 2;
  localparam int PAD_IDX_W  = 2;
  localparam int KRNL_IDX_W = 4;

  localparam int JP_ROWS_LSB   = 0;
  localparam int JP_COLS_LSB   = 16;
  localparam int JP_DEPTH_LSB  = 32;
  localparam int JP_KRNL_LSB   = 48;
  localparam int JP_KSIZE_LSB  = 64;
  localparam int JP_STRIDE_LSB = 68;
  localparam int JP_PAD_LSB    = 72;
  localparam int JP_UPS_BIT    = 76;
  localparam int JP_IDX_LSB    = 80;

  function automatic logic [127:0] pack_job(
    input logic [15:0] rows, cols, depth, kernels,
    input logic [3:0]  ksize, stride, pad,
    input logic        ups,
    input logic [15:0] idx
  );
    logic [127:0] p;
    p = '0;
    p[JP_ROWS_LSB   +: 16] = rows;
    p[JP_COLS_LSB   +: 16] = cols;
    p[JP_DEPTH_LSB  +: 16] = depth;
    p[JP_KRNL_LSB   +: 16] = kernels;
    p[JP_KSIZE_LSB  +: 4]  = ksize;
    p[JP_STRIDE_LSB +: 4]  = stride;
    p[JP_PAD_LSB    +: 4]  = pad;
    p[JP_UPS_BIT]          = ups;
    p[JP_IDX_LSB    +: 16] = idx;
    return p;
  endfunction

endpackage

// File: rtl/cnl_sweep_counter.sv
// Wrap counter for one sweep dimension; chained through cin/cout to form the
// nested loop. cnt_nxt exposes the post-edge value so callers can precompute.
module cnl_sweep_counter #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk_if,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         cin,
  output logic [W-1:0] cnt_nxt,
  output logic         cout
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign cout    = cin & at_last;
  assign cnt_nxt = cnt_d;

  // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cin) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cnl_sweep_job_sequencer.sv
// Walks the img/stride/pad/kernel/upsample parameter space and issues one job
// per point over a start/accept, complete/ack handshake.
module cnl_sweep_job_sequencer
  import cnl_sweep_pkg::*;
#(
  parameter int C_NUM_IMG        = 3,
  parameter int C_NUM_STRD       = 2,
  parameter int C_NUM_PAD        = 2,
  parameter int C_NUM_KRNL       = 5,
  parameter int C_MAX_INPUT_COLS = 512,
  parameter int C_DEPTH          = 4,
  parameter int C_KERNEL_SIZE    = 3
) (
  input  logic         clk_if,
  input  logic         rst_n,
  input  logic         cfg_wr_en,
  input  logic [2:0]   cfg_wr_sel,
  input  logic [3:0]   cfg_wr_idx,
  input  logic [15:0]  cfg_wr_data,
  input  logic         sweep_start,
  input  logic         sweep_abort,
  output logic         sweep_busy,
  output logic         sweep_done,
  output logic         job_start,
  input  logic         job_accept,
  output logic [127:0] job_parameters,
  input  logic         job_complete,
  output logic         job_complete_ack,
  output logic [15:0]  test_idx,
  output logic [15:0]  jobs_issued
);

  sweep_state_e state_q, state_d;

  logic [15:0] img_tbl_q  [MAX_IMG];
  logic [15:0] img_tbl_d  [MAX_IMG];
  logic [3:0]  strd_tbl_q [MAX_STRD];
  logic [3:0]  strd_tbl_d [MAX_STRD];
  logic [3:0]  pad_tbl_q  [MAX_PAD];
  logic [3:0]  pad_tbl_d  [MAX_PAD];
  logic [15:0] krnl_tbl_q [MAX_KRNL];
  logic [15:0] krnl_tbl_d [MAX_KRNL];
  logic [1:0]  ups_mask_q, ups_mask_d;

  logic         ups_q, ups_d;
  logic         abort_q, abort_d;
  logic         job_start_q, job_start_d;
  logic         ack_q, ack_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] job_params_q, job_params_d;
  logic [15:0]  test_idx_q, test_idx_d;
  logic [15:0]  jobs_issued_q, jobs_issued_d;

  logic                  cnt_clr, cnt_en, ups_cout;
  logic                  krnl_cout, pad_cout, strd_cout, img_cout;
  logic [IMG_IDX_W-1:0]  img_nxt;
  logic [STRD_IDX_W-1:0] strd_nxt;
  logic [PAD_IDX_W-1:0]  pad_nxt;
  logic [KRNL_IDX_W-1:0] krnl_nxt;
  logic [15:0]           img_val, rows_val, krnl_val;
  logic [3:0]            strd_val, pad_val;

  assign cnt_clr = (state_q == ST_IDLE) && sweep_start;
  assign cnt_en  = (state_q == ST_ADVANCE);

  // Upsample is the innermost loop: TRUE first, FALSE next, disabled values skipped.
  assign ups_cout = ups_q ? ~ups_mask_q[1] : 1'b1;

  always_comb begin
    ups_d = ups_q;
    if (cnt_clr)     ups_d = ups_mask_q[0];
    else if (cnt_en) ups_d = ups_cout ? ups_mask_q[0] : 1'b0;
  end

  cnl_sweep_counter #(.DEPTH(C_NUM_KRNL), .W(KRNL_IDX_W)) u_krnl_cnt (
    .clk_if(clk_if), .rst_n(rst_n), .clr(cnt_clr), .en(cnt_en),
    .cin(ups_cout), .cnt_nxt(krnl_nxt), .cout(krnl_cout));

  cnl_sweep_counter #(.DEPTH(C_NUM_PAD), .W(PAD_IDX_W)) u_pad_cnt (
    .clk_if(clk_if), .rst_n(rst_n), .clr(cnt_clr), .en(cnt_en),
    .cin(krnl_cout), .cnt_nxt(pad_nxt), .cout(pad_cout));

  cnl_sweep_counter #(.DEPTH(C_NUM_STRD), .W(STRD_IDX_W)) u_strd_cnt (
    .clk_if(clk_if), .rst_n(rst_n), .clr(cnt_clr), .en(cnt_en),
    .cin(pad_cout), .cnt_nxt(strd_nxt), .cout(strd_cout));

  cnl_sweep_counter #(.DEPTH(C_NUM_IMG), .W(IMG_IDX_W)) u_img_cnt (
    .clk_if(clk_if), .rst_n(rst_n), .clr(cnt_clr), .en(cnt_en),
    .cin(strd_cout), .cnt_nxt(img_nxt), .cout(img_cout));

  assign img_val  = img_tbl_q[img_nxt];
  assign strd_val = strd_tbl_q[strd_nxt];
  assign pad_val  = pad_tbl_q[pad_nxt];
  assign krnl_val = krnl_tbl_q[krnl_nxt];
  // Full-width images lose their border when padded by one.
  assign rows_val = (pad_val == 4'd1 && img_val == 16'(C_MAX_INPUT_COLS)) ?
                    img_val - 16'd2 : img_val;

  always_comb begin
    state_d       = state_q;
    img_tbl_d     = img_tbl_q;
    strd_tbl_d    = strd_tbl_q;
    pad_tbl_d     = pad_tbl_q;
    krnl_tbl_d    = krnl_tbl_q;
    ups_mask_d    = ups_mask_q;
    abort_d       = abort_q;
    job_start_d   = 1'b0;
    ack_d         = 1'b0;
    test_idx_d    = test_idx_q;
    jobs_issued_d = jobs_issued_q;
    job_params_d  = job_params_q;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (cfg_wr_en) begin
          case (cfg_wr_sel)
            CFG_IMG:      if (32'(cfg_wr_idx) < C_NUM_IMG)  img_tbl_d[cfg_wr_idx[2:0]]  = cfg_wr_data;
            CFG_STRD:     if (32'(cfg_wr_idx) < C_NUM_STRD) strd_tbl_d[cfg_wr_idx[1:0]] = cfg_wr_data[3:0];
            CFG_PAD:      if (32'(cfg_wr_idx) < C_NUM_PAD)  pad_tbl_d[cfg_wr_idx[1:0]]  = cfg_wr_data[3:0];
            CFG_KRNL:     if (32'(cfg_wr_idx) < C_NUM_KRNL) krnl_tbl_d[cfg_wr_idx]      = cfg_wr_data;
            CFG_UPS_MASK: ups_mask_d = cfg_wr_data[1:0];
            default: ;
          endcase
        end
        if (sweep_start) begin
          test_idx_d    = '0;
          jobs_issued_d = '0;
          if (ups_mask_q == 2'b00) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_ISSUE;
            job_start_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (job_accept) begin
          state_d = ST_WAIT_CMPL;
          abort_d = sweep_abort;
        end else if (sweep_abort) begin
          state_d = ST_DONE;
        end else begin
          job_start_d = 1'b1;
        end
      end
      ST_WAIT_CMPL: begin
        if (sweep_abort) abort_d = 1'b1;
        if (job_complete) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end
      end
      ST_ACK: begin
        if (sweep_abort) abort_d = 1'b1;
        jobs_issued_d = jobs_issued_q + 16'd1;
        state_d       = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (abort_q || sweep_abort || img_cout) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_ISSUE;
          job_start_d = 1'b1;
          test_idx_d  = test_idx_q + 16'd1;
        end
      end
      ST_DONE: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Parameters are frozen on ISSUE entry and stay stable until the next job.
    if (state_d == ST_ISSUE && state_q != ST_ISSUE) begin
      job_params_d = pack_job(rows_val, rows_val, 16'(C_DEPTH), krnl_val,
                              4'(C_KERNEL_SIZE), strd_val, pad_val, ups_d, test_idx_d);
    end
  end

  assign busy_d = (state_d != ST_IDLE);
  assign done_d = (state_d == ST_DONE);

  // NOTE: the tables are reset too; a reset mid-sweep must leave no stale configuration.
  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      img_tbl_q     <= '{default: '0};
      strd_tbl_q    <= '{default: '0};
      pad_tbl_q     <= '{default: '0};
      krnl_tbl_q    <= '{default: '0};
      ups_mask_q    <= 2'b11;
      ups_q         <= 1'b0;
      abort_q       <= 1'b0;
      job_start_q   <= 1'b0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      job_params_q  <= '0;
      test_idx_q    <= '0;
      jobs_issued_q <= '0;
    end else begin
      state_q       <= state_d;
      img_tbl_q     <= img_tbl_d;
      strd_tbl_q    <= strd_tbl_d;
      pad_tbl_q     <= pad_tbl_d;
      krnl_tbl_q    <= krnl_tbl_d;
      ups_mask_q    <= ups_mask_d;
      ups_q         <= ups_d;
      abort_q       <= abort_d;
      job_start_q   <= job_start_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      job_params_q  <= job_params_d;
      test_idx_q    <= test_idx_d;
      jobs_issued_q <= jobs_issued_d;
    end
  end

  assign job_start        = job_start_q;
  assign job_complete_ack = ack_q;
  assign sweep_busy       = busy_q;
  assign sweep_done       = done_q;
  assign job_parameters   = job_params_q;
  assign test_idx         = test_idx_q;
  assign jobs_issued      = jobs_issued_q;

endmodule

// File: tb/tb_cnl_sweep_job_sequencer.sv
// Directed bench for cnl_sweep_job_sequencer: default sweep, abort paths,
// upsample masks, single-point sweep on a depth-1 instance, async reset.
module tb_cnl_sweep_job_sequencer;

  logic         clk_if = 1'b0;
  logic         rst_n;
  logic         cfg_wr_en, sweep_start, sweep_abort, job_accept, job_complete;
  logic [2:0]   cfg_wr_sel;
  logic [3:0]   cfg_wr_idx;
  logic [15:0]  cfg_wr_data;
  logic         sweep_busy, sweep_done, job_start, job_complete_ack;
  logic [127:0] job_parameters;
  logic [15:0]  test_idx, jobs_issued;

  logic         s_cfg_wr_en, s_sweep_start, s_sweep_abort, s_job_accept, s_job_complete;
  logic [2:0]   s_cfg_wr_sel;
  logic [3:0]   s_cfg_wr_idx;
  logic [15:0]  s_cfg_wr_data;
  logic         s_sweep_busy, s_sweep_done, s_job_start, s_job_complete_ack;
  logic [127:0] s_job_parameters;
  logic [15:0]  s_test_idx, s_jobs_issued;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_if = ~clk_if;

  cnl_sweep_job_sequencer u_dut (
    .clk_if(clk_if), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data),
    .sweep_start(sweep_start), .sweep_abort(sweep_abort), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
    .job_complete(job_complete), .job_complete_ack(job_complete_ack),
    .test_idx(test_idx), .jobs_issued(jobs_issued));

  cnl_sweep_job_sequencer #(.C_NUM_IMG(1), .C_NUM_STRD(1), .C_NUM_PAD(1), .C_NUM_KRNL(1)) u_dut1 (
    .clk_if(clk_if), .rst_n(rst_n),
    .cfg_wr_en(s_cfg_wr_en), .cfg_wr_sel(s_cfg_wr_sel), .cfg_wr_idx(s_cfg_wr_idx), .cfg_wr_data(s_cfg_wr_data),
    .sweep_start(s_sweep_start), .sweep_abort(s_sweep_abort), .sweep_busy(s_sweep_busy), .sweep_done(s_sweep_done),
    .job_start(s_job_start), .job_accept(s_job_accept), .job_parameters(s_job_parameters),
    .job_complete(s_job_complete), .job_complete_ack(s_job_complete_ack),
    .test_idx(s_test_idx), .jobs_issued(s_jobs_issued));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  function automatic logic [127:0] exp_job(input int img, input int strd, input int pad,
                                           input int krnl, input bit ups, input int idx);
    logic [127:0] p;
    int r;
    r = (pad == 1 && img == 512) ? img - 2 : img;
    p = '0;
    p[15:0]   = 16'(r);
    p[31:16]  = 16'(r);
    p[47:32]  = 16'd4;
    p[63:48]  = 16'(krnl);
    p[67:64]  = 4'd3;
    p[71:68]  = 4'(strd);
    p[75:72]  = 4'(pad);
    p[76]     = ups;
    p[95:80]  = 16'(idx);
    return p;
  endfunction

  task automatic cfg_write(input logic [2:0] sel, input logic [3:0] idx, input logic [15:0] data);
    cfg_wr_en = 1'b1; cfg_wr_sel = sel; cfg_wr_idx = idx; cfg_wr_data = data;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
  endtask

  // One job on the main DUT; returns at ADVANCE, lat = cycles waited for job_start.
  task automatic do_job(input logic [127:0] exp_p, input logic [15:0] exp_idx, input int acc_dly,
                        input bit poke, input bit abort_wait, input logic [15:0] exp_issued,
                        output int lat);
    int hi;
    lat = 0;
    while (job_start !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("job_start_rise", job_start, 1'b1);
    check("job_params", job_parameters, exp_p);
    check("test_idx", test_idx, exp_idx);
    check("busy_in_job", sweep_busy, 1'b1);
    check("done_mid_sweep", sweep_done, 1'b0);
    hi = 1;
    for (int i = 0; i < acc_dly; i++) begin
      if (poke) begin
        sweep_start = 1'b1; job_complete = 1'b1;
        cfg_wr_en = 1'b1; cfg_wr_sel = 3'd0; cfg_wr_idx = 4'd0; cfg_wr_data = 16'd99;
      end
      tick();
      sweep_start = 1'b0; job_complete = 1'b0; cfg_wr_en = 1'b0;
      if (job_start === 1'b1) hi++;
      check("params_stable", job_parameters, exp_p);
    end
    check("start_hold_cycles", hi, acc_dly + 1);
    job_accept = 1'b1;
    tick();
    job_accept = 1'b0;
    check("start_drop", job_start, 1'b0);
    if (abort_wait) begin
      sweep_abort = 1'b1;
      tick();
      sweep_abort = 1'b0;
    end
    job_complete = 1'b1;
    tick();
    job_complete = 1'b0;
    check("ack_high", job_complete_ack, 1'b1);
    tick();
    check("ack_single", job_complete_ack, 1'b0);
    check("jobs_issued", jobs_issued, exp_issued);
  endtask

  int img_v[3]  = '{7, 20, 512};
  int strd_v[2] = '{1, 2};
  int pad_v[2]  = '{0, 1};
  int krnl_v[5] = '{1, 11, 2, 3, 4};
  int s_sel[5]  = '{0, 1, 2, 3, 4};
  int s_dat[5]  = '{9, 1, 1, 2, 1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, dly, lat, starts;
    rst_n = 1'b0;
    cfg_wr_en = 0; cfg_wr_sel = 0; cfg_wr_idx = 0; cfg_wr_data = 0;
    sweep_start = 0; sweep_abort = 0; job_accept = 0; job_complete = 0;
    s_cfg_wr_en = 0; s_cfg_wr_sel = 0; s_cfg_wr_idx = 0; s_cfg_wr_data = 0;
    s_sweep_start = 0; s_sweep_abort = 0; s_job_accept = 0; s_job_complete = 0;
    #12;
    check("rst_job_start", job_start, 1'b0);
    check("rst_busy", sweep_busy, 1'b0);
    check("rst_done", sweep_done, 1'b0);
    check("rst_ack", job_complete_ack, 1'b0);
    check("rst_params", job_parameters, 128'd0);
    check("rst_test_idx", test_idx, 16'd0);
    check("rst_jobs_issued", jobs_issued, 16'd0);
    check("rst_s_job_start", s_job_start, 1'b0);
    @(posedge clk_if);
    #3 rst_n = 1'b1;
    tick();

    // Default sweep: 3*2*2*5*2 = 120 jobs
    for (int i = 0; i < 3; i++) cfg_write(3'd0, 4'(i), 16'(img_v[i]));
    for (int i = 0; i < 2; i++) cfg_write(3'd1, 4'(i), 16'(strd_v[i]));
    for (int i = 0; i < 2; i++) cfg_write(3'd2, 4'(i), 16'(pad_v[i]));
    for (int i = 0; i < 5; i++) cfg_write(3'd3, 4'(i), 16'(krnl_v[i]));
    cfg_write(3'd5, 4'd0, 16'd0);
    pulse_start();
    idx = 0;
    for (int i = 0; i < 3; i++)
      for (int s = 0; s < 2; s++)
        for (int p = 0; p < 2; p++)
          for (int k = 0; k < 5; k++)
            for (int u = 0; u < 2; u++) begin
              dly = (idx == 10) ? 10 : ((idx == 7) ? 2 : 0);
              do_job(exp_job(img_v[i], strd_v[s], pad_v[p], krnl_v[k], u == 0, idx),
                     16'(idx), dly, idx == 7, 1'b0, 16'(idx + 1), lat);
              check("ack_to_start", lat, (idx == 0) ? 0 : 1);
              idx++;
            end
    tick();
    check("sweep_done_pulse", sweep_done, 1'b1);
    check("final_jobs_issued", jobs_issued, 16'd120);
    check("final_test_idx", test_idx, 16'd119);
    tick();
    check("sweep_done_single", sweep_done, 1'b0);
    check("idle_busy", sweep_busy, 1'b0);

    // Abort in WAIT_CMPL of job 3
    pulse_start();
    do_job(exp_job(7, 1, 0, 1, 1, 0),  16'd0, 0, 1'b0, 1'b0, 16'd1, lat);
    do_job(exp_job(7, 1, 0, 1, 0, 1),  16'd1, 0, 1'b0, 1'b0, 16'd2, lat);
    do_job(exp_job(7, 1, 0, 11, 1, 2), 16'd2, 0, 1'b0, 1'b0, 16'd3, lat);
    do_job(exp_job(7, 1, 0, 11, 0, 3), 16'd3, 0, 1'b0, 1'b1, 16'd4, lat);
    tick();
    check("abort_wait_done", sweep_done, 1'b1);
    check("abort_wait_issued", jobs_issued, 16'd4);
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (job_start === 1'b1) starts++;
    end
    check("abort_wait_no_start", starts, 0);

    // Abort in ISSUE before accept
    pulse_start();
    check("abort_issue_start", job_start, 1'b1);
    sweep_abort = 1'b1;
    tick();
    sweep_abort = 1'b0;
    check("abort_issue_drop", job_start, 1'b0);
    check("abort_issue_done", sweep_done, 1'b1);
    check("abort_issue_issued", jobs_issued, 16'd0);
    tick();
    check("abort_issue_idle", sweep_busy, 1'b0);

    // Empty upsample mask: straight to DONE
    cfg_write(3'd4, 4'd0, 16'd0);
    pulse_start();
    check("mask0_no_start", job_start, 1'b0);
    check("mask0_done", sweep_done, 1'b1);
    check("mask0_busy", sweep_busy, 1'b1);
    tick();
    check("mask0_done_single", sweep_done, 1'b0);
    check("mask0_idle", sweep_busy, 1'b0);

    // Depth-1 instance, mask TRUE only: exactly one job
    for (int i = 0; i < 5; i++) begin
      s_cfg_wr_en = 1'b1; s_cfg_wr_sel = 3'(s_sel[i]); s_cfg_wr_idx = 4'd0; s_cfg_wr_data = 16'(s_dat[i]);
      tick();
    end
    s_cfg_wr_en = 1'b0;
    s_sweep_start = 1'b1;
    tick();
    s_sweep_start = 1'b0;
    check("d1_job_start", s_job_start, 1'b1);
    check("d1_params", s_job_parameters, exp_job(9, 1, 1, 2, 1, 0));
    check("d1_test_idx", s_test_idx, 16'd0);
    s_job_accept = 1'b1;
    tick();
    s_job_accept = 1'b0;
    s_job_complete = 1'b1;
    tick();
    s_job_complete = 1'b0;
    check("d1_ack", s_job_complete_ack, 1'b1);
    tick();
    check("d1_jobs_issued", s_jobs_issued, 16'd1);
    tick();
    check("d1_done", s_sweep_done, 1'b1);
    check("d1_no_second_job", s_job_start, 1'b0);
    tick();
    check("d1_idle", s_sweep_busy, 1'b0);

    // Mask FALSE only, then async reset while in ISSUE
    cfg_write(3'd4, 4'd0, 16'd2);
    pulse_start();
    check("mask2_start", job_start, 1'b1);
    check("mask2_params", job_parameters, exp_job(7, 1, 0, 1, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_job_start", job_start, 1'b0);
    check("async_rst_busy", sweep_busy, 1'b0);
    check("async_rst_params", job_parameters, 128'd0);
    @(posedge clk_if);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_no_ack", job_complete_ack, 1'b0);
    pulse_start();
    check("post_rst_start", job_start, 1'b1);
    check("post_rst_cleared_tables", job_parameters, exp_job(0, 0, 0, 0, 1, 0));
    sweep_abort = 1'b1;
    tick();
    sweep_abort = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
